// File: rtl/uart_rx_word_if.sv
// uart_rx_word_if: serial input plus byte/word output handshake of the UART word receiver
interface uart_rx_word_if;
    logic        rx;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic [31:0] word_data;
    logic        word_valid;
    logic        word_ready;
    logic        frame_err;
    logic        overrun;
    logic        busy;
    modport master (
        input  rx, word_ready,
        output byte_data, byte_valid, word_data, word_valid, frame_err, overrun, busy
    );
    modport slave (
        output rx, word_ready,
        input  byte_data, byte_valid, word_data, word_valid, frame_err, overrun, busy
    );
endinterface

// File: rtl/uart_rx_word.sv
// uart_rx_word: 8N1 UART receiver that packs little-endian bytes into 32-bit words
module uart_rx_word #(
    parameter int WAIT           = 8,
    parameter int BYTES_PER_WORD = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_rx_word_if.master bus
);
    localparam int CW = $clog2(WAIT);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
    state_t        r_state, w_state_nx;
    logic          r_rx_meta, r_rx_s;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic [2:0]    r_bit, w_bit_nx;
    logic [7:0]    r_shift, w_shift_nx;
    logic          w_byte_done, w_ferr;
    logic [1:0]    r_byte_cnt;
    logic [31:0]   r_word_buf, w_word_asm;
    logic          w_word_done, w_accept, w_mid, w_end;
    logic [7:0]    r_byte_data;
    logic          r_byte_valid, r_frame_err, r_overrun, r_word_valid;
    logic [31:0]   r_word_data;

    assign w_mid           = r_cnt == CW'(WAIT / 2 - 1);
    assign w_end           = r_cnt == CW'(WAIT - 1);
    assign w_accept        = r_word_valid & bus.word_ready;
    assign w_word_done     = w_byte_done & (r_byte_cnt == 2'(BYTES_PER_WORD - 1));
    assign bus.byte_data   = r_byte_data;
    assign bus.byte_valid  = r_byte_valid;
    assign bus.word_data   = r_word_data;
    assign bus.word_valid  = r_word_valid;
    assign bus.frame_err   = r_frame_err;
    assign bus.overrun     = r_overrun;
    assign bus.busy        = r_state != S_IDLE;

    // Two-flop synchroniser; idles high so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= bus.rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Receiver state, bit timing and shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_bit   <= w_bit_nx;
            r_shift <= w_shift_nx;
        end
    end

    // Frame sequencing: mid-bit sampling, glitch rejection and break handling
    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt + CW'(1);
        w_bit_nx    = r_bit;
        w_shift_nx  = r_shift;
        w_byte_done = 1'b0;
        w_ferr      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_cnt_nx   = '0;
                w_state_nx = r_rx_s ? S_IDLE : S_START;
            end
            S_START: if (w_mid) begin
                w_cnt_nx   = '0;
                w_bit_nx   = '0;
                w_state_nx = r_rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: if (w_end) begin
                w_cnt_nx   = '0;
                w_shift_nx = {r_rx_s, r_shift[7:1]};
                w_bit_nx   = r_bit + 3'd1;
                w_state_nx = (r_bit == 3'd7) ? S_STOP : S_DATA;
            end
            S_STOP: if (w_end) begin
                w_cnt_nx    = '0;
                w_byte_done = r_rx_s;
                w_ferr      = !r_rx_s;
                w_state_nx  = r_rx_s ? S_IDLE : S_BREAK;
            end
            S_BREAK: begin
                w_cnt_nx   = '0;
                w_state_nx = r_rx_s ? S_IDLE : S_BREAK;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Partial word with the just-received byte dropped into its lane
    always_comb begin
        w_word_asm = r_word_buf;
        for (int k = 0; k < 4; k++)
            if (k == int'(r_byte_cnt)) w_word_asm[8*k +: 8] = r_shift;
    end

    // Byte output, word assembly and the single-entry word output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_data  <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_byte_cnt   <= '0;
            r_word_buf   <= '0;
            r_word_data  <= '0;
            r_word_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_byte_valid <= w_byte_done;
            r_frame_err  <= w_ferr;
            if (w_byte_done) begin
                r_byte_data <= r_shift;
                r_byte_cnt  <= w_word_done ? 2'd0 : r_byte_cnt + 2'd1;
                r_word_buf  <= w_word_done ? '0 : w_word_asm;
            end
            if (w_word_done && (!r_word_valid || w_accept)) begin
                r_word_data  <= w_word_asm;
                r_word_valid <= 1'b1;
            end else if (w_accept) begin
                r_word_valid <= 1'b0;
            end
            if (w_word_done && r_word_valid && !w_accept) r_overrun <= 1'b1;
        end
    end
endmodule
